seg_msg_scroller: RTL and testbench
===================================

SEG_MSG_SCROLLER -- requirements
Module: seg_msg_scroller

Interface
REQ-001 Parameter MSG_DEPTH, default 16, maximum stored message length in glyphs.
REQ-002 Parameter SCROLL_DIV, default 50000000, clk cycles per scroll step (0.5 s at 100 MHz).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 clr  in  1  synchronous message clear, one-cycle pulse.
REQ-006 wr_valid  in  1  glyph write request.
REQ-007 wr_data  in  5  glyph code to append.
REQ-008 wr_ready  out  1  block can accept a glyph this cycle.
REQ-009 scan_idx  in  3  digit position currently enabled by the downstream scanner; 0 = leftmost.
REQ-010 glyph  out  5  glyph code for scan_idx, registered.
REQ-011 msg_len  out  5  number of stored glyphs, 0..MSG_DEPTH.
REQ-012 scrolling  out  1  high while in state SCROLL.

Function
REQ-013 Write accepted iff wr_valid && wr_ready; wr_data stored at index msg_len; msg_len increments by 1 the same edge.
REQ-014 wr_ready = (msg_len < MSG_DEPTH) && !clr, combinational; write attempts while full are dropped, msg_len unchanged.
REQ-015 clr has priority over a same-cycle write: msg_len<=0, offset<=0, tick counter<=0; the write is discarded.
REQ-016 States derived from msg_len each cycle: EMPTY (0), STATIC (1..8), SCROLL (>8); transitions occur the cycle after msg_len changes.
REQ-017 EMPTY: glyph = BLANK (5'h1F) for every scan_idx.
REQ-018 STATIC: glyph = mem[scan_idx] if scan_idx < msg_len, else BLANK; offset held at 0, tick counter held at 0.
REQ-019 SCROLL: virtual length L = msg_len+1 (one trailing BLANK separator); idx = (offset + scan_idx) mod L using a single conditional subtract; glyph = BLANK if idx == msg_len, else mem[idx].
REQ-020 Tick counter counts 0..SCROLL_DIV-1 in SCROLL only; on reaching SCROLL_DIV-1 it returns to 0 and offset advances by 1, wrapping from msg_len to 0.
REQ-021 Writes during SCROLL extend msg_len without altering offset or tick counter.
REQ-022 Entry to SCROLL from STATIC starts with offset 0 and tick counter 0.
REQ-023 glyph latency: exactly 1 clk after any change of scan_idx, offset, memory or msg_len.
REQ-024 Arithmetic: offset and idx are 5-bit unsigned; offset+scan_idx < 2L always, so one subtract suffices.

Reset
REQ-025 On rst_n low: msg_len=0, offset=0, tick counter=0, glyph=BLANK, scrolling=0; wr_ready=1 once rst_n is high.
REQ-026 Glyph memory contents are not reset; they are unreachable while msg_len=0.
REQ-027 Reset asserted mid-scroll returns the block to EMPTY immediately, without waiting for a clk edge.

Structure
REQ-028 Shared package seg_pkg holds GLYPH_W=5, GLYPH_BLANK=5'h1F, glyph codes 0..15 = hex digits 0..F and 16..30 = letters, and the state enumeration.
REQ-029 Single sub-module seg_tick_gen (parameter DIV, inputs clk, rst_n, en, sync clear; output one-cycle tick) implements the scroll divider.
REQ-030 Glyph-to-segment decoding is not part of this block; it is done downstream.

Verification (bench uses SCROLL_DIV=4)
REQ-031 Reset, then write 3,1,4 -> msg_len=3, STATIC; scan_idx 0..7 gives glyph 3,1,4,1F,1F,1F,1F,1F.
REQ-032 Write 10 glyphs 0..9 -> scrolling=1; with offset 0, scan_idx 7 gives 7; after 4 clk, offset 1, scan_idx 0 gives 1, and scan_idx 7 gives 8.
REQ-033 Continue REQ-032 for 11 ticks -> offset sequence 0..10 then 0; at offset 10, scan_idx 0 gives 1F and scan_idx 1 gives 0.
REQ-034 Write 17 glyphs with wr_valid held high -> wr_ready falls after 16th accept, msg_len=16, 17th dropped.
REQ-035 clr and wr_valid in the same cycle during SCROLL -> next cycle msg_len=0, scrolling=0, glyph=1F, write not stored.
REQ-036 Assert rst_n low mid-scroll (offset=5) -> outputs reach reset values without a clk edge; after release, msg_len=0 and wr_ready=1.

Source files
------------

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment message scroller.
//   GLYPH_W        width of a glyph code
//   GLYPH_BLANK    code that lights no segments
//   glyph codes    0..15 are the hex digits 0..F, 16..30 are letters,
//                  31 is BLANK
//   DISPLAY_DIGITS number of physical digits driven by the scanner
//   scroll_state_e display mode, derived from the stored message length
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int GLYPH_W = 5;
  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'h1F;

  localparam logic [GLYPH_W-1:0] GLYPH_HEX_FIRST    = 5'd0;
  localparam logic [GLYPH_W-1:0] GLYPH_HEX_LAST     = 5'd15;
  localparam logic [GLYPH_W-1:0] GLYPH_LETTER_FIRST = 5'd16;
  localparam logic [GLYPH_W-1:0] GLYPH_LETTER_LAST  = 5'd30;

  localparam int DISPLAY_DIGITS = 8;

  localparam int LEN_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2
  } scroll_state_e;

  // A message that fits on the physical digits is shown still; anything
  // longer has to scroll.
  function automatic scroll_state_e state_for_len(input logic [LEN_W-1:0] len);
    scroll_state_e st;
    if (len == '0) begin
      st = ST_EMPTY;
    end else if (len <= LEN_W'(DISPLAY_DIGITS)) begin
      st = ST_STATIC;
    end else begin
      st = ST_SCROLL;
    end
    return st;
  endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// ---------------------------------------------------------------------------
// seg_tick_gen
// Free-running divider that produces a one-cycle tick every DIV enabled
// clock cycles.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   en     count only while high; the count is held at zero otherwise
//   clr    synchronous clear of the count
//   tick   high for the single cycle in which the count sits at DIV-1
// ---------------------------------------------------------------------------
module seg_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // The tick is decoded combinationally from the count so the consumer sees
  // it in the same cycle the count reaches its terminal value.
  assign tick = en && (cnt == CW'(DIV - 1));

  // Disabling the divider also zeroes it, so every enable period starts a
  // full DIV-cycle interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_msg_scroller.sv
// ---------------------------------------------------------------------------
// seg_msg_scroller
// Stores a short message of glyph codes and presents, for the digit the
// downstream scanner is enabling, the glyph that belongs there. Messages of
// up to DISPLAY_DIGITS glyphs are shown still; longer ones scroll left with
// one blank separator between the end and the restart of the message.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous message clear (wins over a same-cycle write)
//   wr_valid   append request for wr_data
//   wr_data    glyph code to append
//   wr_ready   a write can be accepted this cycle
//   scan_idx   digit currently enabled by the scanner, 0 = leftmost
//   glyph      registered glyph code for scan_idx
//   msg_len    number of stored glyphs
//   scrolling  high while the message is scrolling
// Parameters
//   MSG_DEPTH  glyph storage depth (at most 24 so offset+scan_idx fits 5 bits)
//   SCROLL_DIV clk cycles per scroll step
// ---------------------------------------------------------------------------
module seg_msg_scroller
  import seg_pkg::*;
#(
  parameter int MSG_DEPTH  = 16,
  parameter int SCROLL_DIV = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_valid,
  input  logic [GLYPH_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic [2:0]         scan_idx,
  output logic [GLYPH_W-1:0] glyph,
  output logic [LEN_W-1:0]   msg_len,
  output logic               scrolling
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

  logic [GLYPH_W-1:0] mem [MSG_DEPTH];

  scroll_state_e state_q;
  scroll_state_e state_d;

  logic               wr_fire;
  logic               step_tick;
  logic [LEN_W-1:0]   offset;
  logic [LEN_W-1:0]   scan_ext;
  logic [LEN_W-1:0]   pos_sum;
  logic [LEN_W-1:0]   virt_len;
  logic [LEN_W-1:0]   pos_idx;
  logic [GLYPH_W-1:0] glyph_d;

  assign wr_ready = (msg_len < LEN_W'(MSG_DEPTH)) && !clr;
  assign wr_fire  = wr_valid && wr_ready;

  // Glyph storage has no reset: entries above msg_len are never selected, so
  // their contents are irrelevant.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[msg_len[AW-1:0]] <= wr_data;
    end
  end

  // Message length; a clear discards everything including a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len <= '0;
    end else if (clr) begin
      msg_len <= '0;
    end else if (wr_fire) begin
      msg_len <= msg_len + 1'b1;
    end
  end

  // Display mode register; it follows msg_len one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next mode from the current length. A clear forces EMPTY directly so that
  // scrolling drops on the same edge that empties the message.
  always_comb begin
    state_d   = state_for_len(msg_len);
    scrolling = 1'b0;
    if (clr) begin
      state_d = ST_EMPTY;
    end
    scrolling = (state_q == ST_SCROLL);
  end

  seg_tick_gen #(
    .DIV (SCROLL_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_SCROLL),
    .clr   (clr),
    .tick  (step_tick)
  );

  // Scroll offset runs 0..msg_len; position msg_len is the blank separator.
  // Outside SCROLL it is pinned at zero so every scroll starts from the
  // first glyph. Writes while scrolling only lengthen the loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
    end else if (clr || (state_q != ST_SCROLL)) begin
      offset <= '0;
    end else if (step_tick) begin
      offset <= (offset == msg_len) ? '0 : offset + 1'b1;
    end
  end

  // Glyph selection. The mode is decoded from msg_len itself rather than the
  // state register, so a new length is reflected one cycle later without
  // waiting for the state to catch up. offset+scan_idx is below twice the
  // virtual length, hence one conditional subtract gives the modulo.
  always_comb begin
    scan_ext = {2'b00, scan_idx};
    pos_sum  = offset + scan_ext;
    virt_len = msg_len + 1'b1;
    pos_idx  = (pos_sum >= virt_len) ? (pos_sum - virt_len) : pos_sum;
    glyph_d  = GLYPH_BLANK;
    if (msg_len == '0) begin
      glyph_d = GLYPH_BLANK;
    end else if (msg_len <= LEN_W'(DISPLAY_DIGITS)) begin
      if (scan_ext < msg_len) begin
        glyph_d = mem[scan_ext[AW-1:0]];
      end
    end else if (pos_idx != msg_len) begin
      glyph_d = mem[pos_idx[AW-1:0]];
    end
  end

  // Output register; a clear blanks the display on the same edge it empties
  // the message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph <= GLYPH_BLANK;
    end else if (clr) begin
      glyph <= GLYPH_BLANK;
    end else begin
      glyph <= glyph_d;
    end
  end

endmodule

// File: tb/tb_seg_msg_scroller.sv
// ---------------------------------------------------------------------------
// tb_seg_msg_scroller
// Self-checking bench for seg_msg_scroller with a small scroll divider.
// A behavioural model tracks the stored message, length, scroll offset and
// divider phase, and derives each expected glyph with a plain modulo.
// ---------------------------------------------------------------------------
module tb_seg_msg_scroller;

  localparam int DEPTH = 16;
  localparam int DIV   = 4;
  localparam logic [4:0] BLANK = 5'h1F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       wr_valid;
  logic [4:0] wr_data;
  logic       wr_ready;
  logic [2:0] scan_idx;
  logic [4:0] glyph;
  logic [4:0] msg_len;
  logic       scrolling;

  int checks   = 0;
  int failures = 0;

  int         mdlLen;
  int         mdlOff;
  int         mdlCnt;
  bit         mdlScroll;
  logic [4:0] mdlMem [DEPTH];
  logic [4:0] expGlyph;

  seg_msg_scroller #(
    .MSG_DEPTH  (DEPTH),
    .SCROLL_DIV (DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .scan_idx  (scan_idx),
    .glyph     (glyph),
    .msg_len   (msg_len),
    .scrolling (scrolling)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // What the display should show for a message of length len at scroll
  // position off, on digit scan.
  function automatic logic [4:0] refGlyph(input int len, input int off, input int scan);
    int pos;
    if (len == 0) return BLANK;
    if (len <= 8) return (scan < len) ? mdlMem[scan] : BLANK;
    pos = (off + scan) % (len + 1);
    return (pos == len) ? BLANK : mdlMem[pos];
  endfunction

  task automatic modelReset();
    mdlLen    = 0;
    mdlOff    = 0;
    mdlCnt    = 0;
    mdlScroll = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelEdge();
    bit nextScroll;
    expGlyph   = clr ? BLANK : refGlyph(mdlLen, mdlOff, int'(scan_idx));
    nextScroll = !clr && (mdlLen > 8);
    if (mdlScroll && !clr) begin
      if (mdlCnt == DIV - 1) begin
        mdlCnt = 0;
        mdlOff = (mdlOff + 1) % (mdlLen + 1);
      end else begin
        mdlCnt++;
      end
    end else begin
      mdlCnt = 0;
      mdlOff = 0;
    end
    if (clr) begin
      mdlLen = 0;
    end else if (wr_valid && (mdlLen < DEPTH)) begin
      mdlMem[mdlLen] = wr_data;
      mdlLen++;
    end
    mdlScroll = nextScroll;
  endtask

  // One clock cycle: drive on the falling edge, check wr_ready before the
  // rising edge, then check the registered outputs just after it.
  task automatic applyStimulus(input logic c, input logic v, input logic [4:0] d,
                               input logic [2:0] s);
    @(negedge clk);
    clr      = c;
    wr_valid = v;
    wr_data  = d;
    scan_idx = s;
    #1;
    checkOutput("wr_ready", 32'(wr_ready), 32'((mdlLen < DEPTH) && !c));
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("msg_len", 32'(msg_len), 32'(mdlLen));
    checkOutput("scrolling", 32'(scrolling), 32'(mdlScroll));
    checkOutput("glyph", 32'(glyph), 32'(expGlyph));
  endtask

  task automatic runUntilOffset(input int target, input int budget);
    int n;
    n = 0;
    while ((mdlOff != target) && (n < budget)) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
      n++;
    end
    if (mdlOff != target) begin
      checkOutput("offset_timeout", 32'(mdlOff), 32'(target));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] exp31 [8];
    exp31 = '{5'd3, 5'd1, 5'd4, BLANK, BLANK, BLANK, BLANK, BLANK};

    rst_n    = 1'b0;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    scan_idx = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("rst_glyph", 32'(glyph), 32'(BLANK));
    checkOutput("rst_msg_len", 32'(msg_len), 32'd0);
    checkOutput("rst_scrolling", 32'(scrolling), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);

    $display("[TB] static message 3,1,4");
    applyStimulus(1'b0, 1'b1, 5'd3, 3'd0);
    applyStimulus(1'b0, 1'b1, 5'd1, 3'd0);
    applyStimulus(1'b0, 1'b1, 5'd4, 3'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 3'(i));
      checkOutput("static_glyph", 32'(glyph), 32'(exp31[i]));
    end
    checkOutput("static_len", 32'(msg_len), 32'd3);

    $display("[TB] scrolling message 0..9");
    applyStimulus(1'b1, 1'b0, 5'd0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 3'd0);
    end
    checkOutput("scroll_on", 32'(scrolling), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd7);
    checkOutput("off0_scan7", 32'(glyph), 32'd7);
    repeat (3) applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
    checkOutput("off1_scan0", 32'(glyph), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd7);
    checkOutput("off1_scan7", 32'(glyph), 32'd8);

    runUntilOffset(10, 60);
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
    checkOutput("off10_scan0", 32'(glyph), 32'(BLANK));
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd1);
    checkOutput("off10_scan1", 32'(glyph), 32'd0);
    runUntilOffset(0, 20);
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
    checkOutput("wrap_scan0", 32'(glyph), 32'd0);

    $display("[TB] reset mid-scroll");
    runUntilOffset(5, 40);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_glyph", 32'(glyph), 32'(BLANK));
    checkOutput("midrst_msg_len", 32'(msg_len), 32'd0);
    checkOutput("midrst_scrolling", 32'(scrolling), 32'd0);
    #1 rst_n = 1'b1;
    modelReset();
    #0;
    checkOutput("postrst_msg_len", 32'(msg_len), 32'd0);
    checkOutput("postrst_wr_ready", 32'(wr_ready), 32'd1);

    $display("[TB] overfill");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i + 8), 3'(i));
    end
    checkOutput("full_len", 32'(msg_len), 32'd16);
    #1;
    checkOutput("full_wr_ready", 32'(wr_ready), 32'd0);

    $display("[TB] clear with write while scrolling");
    applyStimulus(1'b1, 1'b1, 5'd10, 3'd2);
    checkOutput("clr_len", 32'(msg_len), 32'd0);
    checkOutput("clr_scrolling", 32'(scrolling), 32'd0);
    checkOutput("clr_glyph", 32'(glyph), 32'(BLANK));
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0);
    checkOutput("clr_nowrite", 32'(msg_len), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 700; i++) begin
      applyStimulus(1'($urandom_range(0, 59) == 0),
                    1'($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 31)),
                    3'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
